param_serializer: RTL and testbench

- Parametrised successor to the fixed 16-bit serializer. Takes one parallel word with a per-word bit count and bit-order select, and shifts it out one bit per clock.
- Output carries a valid flag and a last-bit flag. A busy flag gives upstream back-pressure.
- Sits between a parallel producer and a bit-serial link or framer.

---
 rtl/param_serializer_pkg.sv | 8 +
 rtl/param_serializer.sv | 71 +++++++
 tb/tb_param_serializer.sv | 122 ++++++++++++
 3 files changed

// File: rtl/param_serializer_pkg.sv
// serializer_pkg: shared FSM state type and length decoding for param_serializer
package serializer_pkg;
  typedef enum logic {IDLE, SHIFT} state_t;
  function automatic int unsigned len_decode(input int unsigned mod, input int unsigned data_w,
                                             input int unsigned min_len = 3);
    return (mod == 0) ? data_w : ((mod < min_len) ? 0 : mod);
  endfunction
endpackage

// File: rtl/param_serializer.sv
// param_serializer: parallel-to-serial shifter with length/order select; SERIALIZER_BACK2BACK_EN enables gapless streaming
module param_serializer
  import serializer_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int MOD_W   = $clog2(DATA_W),
  parameter int MIN_LEN = 3
) (
  input  logic              clk_i,
  input  logic              srst_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [MOD_W-1:0]  data_mod_i,
  input  logic              data_val_i,
  input  logic              msb_first_i,
  output logic              ser_data_o,
  output logic              ser_data_val_o,
  output logic              ser_data_last_o,
  output logic              busy_o
);
  localparam int CW = MOD_W + 1;
`ifdef SERIALIZER_BACK2BACK_EN
  localparam bit B2B = 1'b1;
`else
  localparam bit B2B = 1'b0;
`endif
  state_t state_q, state_d;
  logic [DATA_W-1:0] sh_q, sh_d;
  logic [CW-1:0] cnt_q, cnt_d, len;
  logic msb_q, msb_d, data_q, data_d, val_q, val_d, last_q, last_d, busy_q, busy_d;
  logic accept, shifting;
  // next-state: accept a legal word when not busy, otherwise keep shifting until the counter expires
  always_comb begin
    len      = CW'(len_decode(32'(data_mod_i), DATA_W, MIN_LEN));
    accept   = data_val_i && !busy_q && len != '0;
    shifting = state_q == SHIFT && cnt_q != '0;
    state_d  = (accept || shifting) ? SHIFT : IDLE;
    sh_d     = accept ? data_i : (msb_q ? sh_q << 1 : sh_q >> 1);
    cnt_d    = accept ? len - CW'(1) : (shifting ? cnt_q - CW'(1) : cnt_q);
    msb_d    = accept ? msb_first_i : msb_q;
    val_d    = state_d == SHIFT;
    data_d   = val_d && (msb_d ? sh_d[DATA_W-1] : sh_d[0]);
    last_d   = val_d && cnt_d == '0;
    busy_d   = val_d && !(B2B && last_d);
  end
  // state and registered outputs; reset abandons any word in flight
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      state_q <= IDLE;
      sh_q    <= '0;
      cnt_q   <= '0;
      msb_q   <= 1'b0;
      data_q  <= 1'b0;
      val_q   <= 1'b0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      cnt_q   <= cnt_d;
      msb_q   <= msb_d;
      data_q  <= data_d;
      val_q   <= val_d;
      last_q  <= last_d;
      busy_q  <= busy_d;
    end
  end
  assign ser_data_o      = data_q;
  assign ser_data_val_o  = val_q;
  assign ser_data_last_o = last_q;
  assign busy_o          = busy_q;
endmodule

// File: tb/tb_param_serializer.sv
// tb_param_serializer: directed self-checking bench for param_serializer
module tb_param_serializer;
`ifdef SERIALIZER_BACK2BACK_EN
  localparam bit B2B = 1'b1;
`else
  localparam bit B2B = 1'b0;
`endif
  logic clk = 1'b0, srst_i = 1'b0, data_val_i = 1'b0, msb_first_i = 1'b0;
  logic [15:0] data_i = '0;
  logic [3:0] data_mod_i = '0;
  logic ser_data_o, ser_data_val_o, ser_data_last_o, busy_o;
  int total = 0, fails = 0;

  param_serializer dut (
    .clk_i(clk), .srst_i(srst_i), .data_i(data_i), .data_mod_i(data_mod_i),
    .data_val_i(data_val_i), .msb_first_i(msb_first_i), .ser_data_o(ser_data_o),
    .ser_data_val_o(ser_data_val_o), .ser_data_last_o(ser_data_last_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    chk({tag, ".val"}, ser_data_val_o, 1'b0);
    chk({tag, ".data"}, ser_data_o, 1'b0);
    chk({tag, ".last"}, ser_data_last_o, 1'b0);
    chk({tag, ".busy"}, busy_o, 1'b0);
  endtask

  task automatic check_bit(input string tag, input logic b, input logic last);
    chk({tag, ".val"}, ser_data_val_o, 1'b1);
    chk({tag, ".data"}, ser_data_o, b);
    chk({tag, ".last"}, ser_data_last_o, last);
    chk({tag, ".busy"}, busy_o, B2B ? !last : 1'b1);
  endtask

  // exp holds the expected emission order starting at bit 15
  task automatic check_word(input string tag, input logic [15:0] exp, input int n, input int inject_at);
    for (int i = 0; i < n; i++) begin
      check_bit($sformatf("%s[%0d]", tag, i), exp[15-i], i == n - 1);
      if (i == inject_at) begin
        data_val_i = 1'b1; data_i = 16'h0000; data_mod_i = 4'd0; msb_first_i = 1'b0;
      end
      step();
      if (i == inject_at) data_val_i = 1'b0;
    end
  endtask

  task automatic send(input logic [15:0] d, input logic [3:0] m, input logic msb);
    data_i = d; data_mod_i = m; msb_first_i = msb; data_val_i = 1'b1;
    step();
    data_val_i = 1'b0;
  endtask

  initial begin
    srst_i = 1'b1;
    step(); step();
    srst_i = 1'b0;
    check_idle("reset");
    send(16'hA5F0, 4'd0, 1'b1);
    check_word("a5f0", 16'hA5F0, 16, -1);
    check_idle("after_a5f0");
    send(16'hB800, 4'd5, 1'b1);
    check_word("b800", 16'hB800, 5, -1);
    check_idle("after_b800");
    send(16'h000D, 4'd4, 1'b0);
    check_word("000d_lsb", 16'hB000, 4, -1);
    check_idle("after_000d");
    send(16'hFFFF, 4'd1, 1'b1);
    check_idle("drop_mod1");
    send(16'hFFFF, 4'd2, 1'b0);
    check_idle("drop_mod2");
    send(16'h0005, 4'd3, 1'b0);
    check_word("mod3", 16'hA000, 3, -1);
    check_idle("after_mod3");
    send(16'hF00F, 4'd8, 1'b1);
    check_word("midpulse", 16'hF000, 8, 2);
    check_idle("after_midpulse");
    send(16'hFFFF, 4'd0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      check_bit($sformatf("pre_rst[%0d]", i), 1'b1, 1'b0);
      step();
    end
    check_bit("pre_rst[5]", 1'b1, 1'b0);
    srst_i = 1'b1;
    step();
    check_idle("mid_rst");
    srst_i = 1'b0;
    send(16'h9000, 4'd4, 1'b1);
    check_word("post_rst", 16'h9000, 4, -1);
    check_idle("after_post_rst");
    send(16'hC000, 4'd4, 1'b1);
    for (int i = 0; i < 4; i++) begin
      check_bit($sformatf("b2b_a[%0d]", i), i < 2, i == 3);
      if (i == 3) begin
        data_i = 16'h000A; data_mod_i = 4'd4; msb_first_i = 1'b0; data_val_i = 1'b1;
      end
      step();
    end
    if (!B2B) begin
      check_idle("b2b_gap");
      step();
    end
    data_val_i = 1'b0;
    check_word("b2b_b", 16'h5000, 4, -1);
    check_idle("after_b2b");
    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end
endmodule
